pong_video_out: RTL
===================

// Module: pong_video_out
// PURPOSE
//  Consumer side of the position interface driven by the Nios system: samples ball/paddle coordinates
//  (bx, by, p1x, p1y, p2x, p2y) once per frame and renders the Pong field on a 640x480@60 VGA output.
//  Drives busy back to the Nios (busy_export) so software updates positions only during vertical blank.
//  Sits beside the nios instance in the pong top level, between its PIO outputs and the VGA DAC pins.
// PARAMETERS
//  CLK_DIV   2   clk_clk cycles per pixel (50 MHz board clock -> 25 MHz pixel enable); legal values 1..4
//  BALL_SZ   8   ball edge length, pixels (square)
//  PAD_W     8   paddle width, pixels
//  PAD_H     64  paddle height, pixels
// PORTS
//  clk_clk      in   1   system clock, same clock as the nios instance
//  reset_reset  in   1   synchronous, active-high reset
//  bx, by       in   10  ball top-left x/y, pixels
//  p1x, p1y     in   10  paddle 1 top-left x/y
//  p2x, p2y     in   10  paddle 2 top-left x/y
//  busy         out  1   1 = do not update positions (active video or snapshot line)
//  frame_tick   out  1   one clk_clk pulse when a new snapshot is taken
//  vga_hs       out  1   horizontal sync, active low
//  vga_vs       out  1   vertical sync, active low
//  vga_r/g/b    out  1   colour bits, one each
// BEHAVIOUR
//  - Pixel enable pe: free-running divider, pulses once every CLK_DIV clocks. All counters and outputs
//    advance only on pe, except frame_tick.
//  - hcnt 0..799, vcnt 0..524. At hcnt=799, hcnt wraps to 0 and vcnt increments; vcnt wraps 524->0.
//  - Sync: hs low for hcnt 656..751; vs low for vcnt 490..491. Active region: hcnt<640 && vcnt<480.
//  - Snapshot: on pe with hcnt=799 && vcnt=524, all six inputs are copied into shadow registers, and
//    frame_tick pulses for exactly one clk_clk cycle. Rendering uses only the shadow values.
//  - busy = (vcnt<480) || (vcnt==524), registered. It is low for lines 480..523; inputs may change then.
//  - Hit tests use 11-bit zero-extended arithmetic, with no 10-bit wrap:
//    ball hit when h>=sbx && h<sbx+BALL_SZ && v>=sby && v<sby+BALL_SZ; paddles likewise with PAD_W/PAD_H.
//  - Colour priority: ball=white 111 > paddle1=red 100 > paddle2=green 010 > background 000.
//    Colour is forced to 000 outside the active region.
//  - Latency: rgb, hs and vs are all registered in one stage. Outputs for counter position (h,v) appear
//    at the pe following the one on which the counters read (h,v). Sync and colour stay mutually aligned.
//  - Objects partly or wholly off-screen are clipped naturally; coordinates >=640/480 draw nothing.
//  - Reset values: hcnt=vcnt=0, divider=0, shadow regs=0, vga_r/g/b=0, vga_hs=vga_vs=1, busy=1,
//    frame_tick=0.
//  - Reset asserted mid-frame: reset wins in that cycle. The frame restarts at (0,0) with no snapshot
//    taken until the next line 524 end.
// STRUCTURE
//  - Package pong_video_pkg: H_ACTIVE=640, H_FP=16, H_SYNC=96, H_TOTAL=800, V_ACTIVE=480, V_FP=10,
//    V_SYNC=2, V_TOTAL=525, and RGB colour constants.
//  - Sub-module vga_timing: divider, hcnt/vcnt, raw hs/vs/active, snap strobe.
//  - The top holds the shadow regs, hit tests, priority mux and output registers.
// TESTING
//  1. Reset held 3 clocks mid-frame -> hs=vs=1, rgb=0, busy=1, frame_tick=0; first hs low 657 pe after
//     release (656 counts + 1 register stage).
//  2. Free run 2 frames, CLK_DIV=2 -> hs period 1600 clk, vs period 840000 clk, vs low 2 lines,
//     frame_tick once per frame.
//  3. busy timing -> falls when vcnt becomes 480, rises when vcnt becomes 524, high through lines 0..479.
//  4. Change bx from 100 to 300 during vblank -> next frame draws white at h=300..307 only.
//     Changing bx during active video does not alter the current frame.
//  5. bx=636, by=0 -> white at h=636..639, rows 0..7; no wrap to h=0..3.
//     bx=1020 -> no white pixels anywhere.
//  6. Ball over paddle1 (bx=p1x=20, by=p1y=100) -> overlap pixels are 111.
//     Paddle1 and paddle2 overlapping -> 100.

Source files
------------

// File: rtl/pong_video_pkg.sv
// pong_video_pkg: VGA 640x480@60 timing constants, colours and position snapshot type
package pong_video_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_TOTAL  = 800;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;
    typedef logic [2:0] rgb_t;
    localparam rgb_t RGB_BLACK = 3'b000;
    localparam rgb_t RGB_WHITE = 3'b111;
    localparam rgb_t RGB_RED   = 3'b100;
    localparam rgb_t RGB_GREEN = 3'b010;
    typedef struct packed {
        logic [9:0] bx;
        logic [9:0] by;
        logic [9:0] p1x;
        logic [9:0] p1y;
        logic [9:0] p2x;
        logic [9:0] p2y;
    } pos_t;
    // 11-bit compare so objects near 1023 clip instead of wrapping to 0
    function automatic logic hit(input logic [9:0] p, input logic [9:0] org, input int unsigned size);
        return {1'b0, p} >= {1'b0, org} && {1'b0, p} < {1'b0, org} + 11'(size);
    endfunction
endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel-enable divider, h/v counters, raw syncs, active flag and snapshot strobe
module vga_timing
    import pong_video_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int VA      = V_ACTIVE,
    parameter int VFP     = V_FP,
    parameter int VSY     = V_SYNC,
    parameter int VT      = V_TOTAL
) (
    input  logic       clk,
    input  logic       rst,
    output logic       pe,
    output logic [9:0] hcnt,
    output logic [9:0] vcnt,
    output logic       hs,
    output logic       vs,
    output logic       active,
    output logic       snap
);
    logic [1:0] div;
    logic       h_last;
    assign pe     = div == 2'(CLK_DIV - 1);
    assign h_last = hcnt == 10'(H_TOTAL - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            div  <= '0;
            hcnt <= '0;
            vcnt <= '0;
        end else begin
            div <= pe ? 2'd0 : div + 2'd1;
            if (pe) begin
                hcnt <= h_last ? 10'd0 : hcnt + 10'd1;
                if (h_last)
                    vcnt <= vcnt == 10'(VT - 1) ? 10'd0 : vcnt + 10'd1;
            end
        end
    end
    assign hs     = !(hcnt >= 10'(H_ACTIVE + H_FP) && hcnt < 10'(H_ACTIVE + H_FP + H_SYNC));
    assign vs     = !(vcnt >= 10'(VA + VFP) && vcnt < 10'(VA + VFP + VSY));
    assign active = hcnt < 10'(H_ACTIVE) && vcnt < 10'(VA);
    assign snap   = pe && h_last && vcnt == 10'(VT - 1);
endmodule

// File: rtl/pong_video_out.sv
// pong_video_out: per-frame position snapshot, Pong field renderer and registered VGA outputs
module pong_video_out
    import pong_video_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int BALL_SZ = 8,
    parameter int PAD_W   = 8,
    parameter int PAD_H   = 64,
    parameter int VA      = V_ACTIVE,
    parameter int VFP     = V_FP,
    parameter int VSY     = V_SYNC,
    parameter int VT      = V_TOTAL
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic [9:0] bx,
    input  logic [9:0] by,
    input  logic [9:0] p1x,
    input  logic [9:0] p1y,
    input  logic [9:0] p2x,
    input  logic [9:0] p2y,
    output logic       busy,
    output logic       frame_tick,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_r,
    output logic       vga_g,
    output logic       vga_b
);
    logic       pe, hs_raw, vs_raw, active, snap;
    logic [9:0] hcnt, vcnt;
    pos_t       sh;
    logic       ball, pad1, pad2;
    rgb_t       colour;

    vga_timing #(.CLK_DIV(CLK_DIV), .VA(VA), .VFP(VFP), .VSY(VSY), .VT(VT)) u_timing (
        .clk(clk_clk),
        .rst(reset_reset),
        .pe(pe),
        .hcnt(hcnt),
        .vcnt(vcnt),
        .hs(hs_raw),
        .vs(vs_raw),
        .active(active),
        .snap(snap)
    );

    always_comb begin
        ball   = hit(hcnt, sh.bx, BALL_SZ) && hit(vcnt, sh.by, BALL_SZ);
        pad1   = hit(hcnt, sh.p1x, PAD_W) && hit(vcnt, sh.p1y, PAD_H);
        pad2   = hit(hcnt, sh.p2x, PAD_W) && hit(vcnt, sh.p2y, PAD_H);
        colour = !active ? RGB_BLACK : ball ? RGB_WHITE : pad1 ? RGB_RED : pad2 ? RGB_GREEN : RGB_BLACK;
    end

    // sync and colour share one register stage so they stay aligned
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            sh                    <= '0;
            {vga_r, vga_g, vga_b} <= RGB_BLACK;
            vga_hs                <= 1'b1;
            vga_vs                <= 1'b1;
            busy                  <= 1'b1;
            frame_tick            <= 1'b0;
        end else begin
            frame_tick <= snap;
            if (snap)
                sh <= '{bx: bx, by: by, p1x: p1x, p1y: p1y, p2x: p2x, p2y: p2y};
            if (pe) begin
                {vga_r, vga_g, vga_b} <= colour;
                vga_hs                <= hs_raw;
                vga_vs                <= vs_raw;
                busy                  <= vcnt < 10'(VA) || vcnt == 10'(VT - 1);
            end
        end
    end
endmodule
